regfile_write_arbiter: RTL
==========================

# regfile_write_arbiter

Single-write-port arbiter and initialiser for the LC-3 eight-entry, 16-bit register file. It shares the one `LD_REG`/`DR`/`Data_In` write port between two requesters: A is the CPU write-back path and B is the debug/host loader. After reset, or on command, it clears R0–R7 to zero in sequence before accepting any requests. It sits directly in front of the register file; the read ports are not touched.

## Interface
- `DATA_W`, 16, register width.
- `ADDR_W`, 3, register index width.
- `NUM_REGS`, 8, registers cleared by the init sequence; equals 2^ADDR_W.

- `Clk` in 1: rising-edge clock.
- `Reset` in 1: asynchronous, active-low reset.
- `A_Req` in 1: requester A write request.
- `A_DR` in ADDR_W: requester A destination register.
- `A_Data` in DATA_W: requester A write data.
- `A_Ack` out 1: write for A issued this cycle.
- `B_Req`, `B_DR`, `B_Data`, `B_Ack`: same as the A ports, for requester B.
- `Init_Start` in 1: one-cycle pulse that requests a full re-clear.
- `LD_REG` out 1: register file write enable.
- `DR` out ADDR_W: register file destination.
- `Data_In` out DATA_W: register file write data.
- `Init_Busy` out 1: high while the clear sequence runs.

## Operation
- **Registered outputs.** All outputs are registered.
- **Reset values** while `Reset`=0:
  - `LD_REG`=0, `DR`=0, `Data_In`=0.
  - `A_Ack`=0, `B_Ack`=0.
  - `Init_Busy`=1, state=INIT, init counter=0, round-robin pointer=A.
- **INIT state.** Each cycle the arbiter issues `LD_REG`=1, `DR`=counter, `Data_In`=0, then increments the counter.
  - After it issues `DR`=NUM_REGS-1, it moves to ARB.
  - Requests are not sampled and no Ack is given during INIT.
  - `Init_Start` is ignored during INIT.
- **ARB state.** At each edge, `Req` is sampled from every requester whose Ack is currently low. A requester whose Ack is high this cycle is ineligible at this edge.
  - **One requester eligible:** it is granted.
  - **Both eligible:** the pointer holder is granted. After any grant, the pointer moves to the other requester.
  - **On grant:** next cycle `LD_REG`=1, `DR`/`Data_In` equal the granted requester's sampled values, and that requester's Ack=1 for exactly one cycle.
  - **No grant:** next cycle `LD_REG`=0, both Acks=0. `DR`/`Data_In` hold their last values.
- **Requester protocol.** A requester holds `Req`/`DR`/`Data` stable until its Ack is high. During the Ack cycle it may drop `Req` or present a new request, which will be sampled at the next edge.
- **`Init_Start` in ARB** (sampled high at an edge):
  - Takes priority over any request at that edge; no grant is made.
  - The arbiter enters INIT with counter=0 and `Init_Busy`=1. Pending requests stay pending with no Ack.
  - A write already being issued in the current cycle completes.
- **Same `DR` from A and B.** No merging. Writes happen in grant order, so the later grant's data persists.
- **Reset asserted mid-operation.** Outputs go to their reset values immediately. Any partial clear restarts from R0 after `Reset` rises.
- **No combinational paths** from inputs to outputs.

## Timing
- **Edge numbering.** Edge 1 is the first rising `Clk` after `Reset` goes high.
- **Init sequence.**
  - After edge k (1..8): `LD_REG`=1, `DR`=k-1, `Data_In`=0.
  - After edge 9: `LD_REG`=0, `Init_Busy`=0, state=ARB.
- **First request.** The earliest request sample is edge 10. The earliest Ack and write are visible after edge 10.
- **Latency.** A request sampled at edge t appears as Ack and `LD_REG` after edge t; the register file captures the data at edge t+1.
- **Throughput.**
  - A single requester gets at most one write every 2 cycles.
  - With two alternating requesters the port sustains one write per cycle.
- **Re-clear length.** `Init_Start` sampled at edge t: `Init_Busy`=1 after t, 8 writes after edges t+1..t+8, `Init_Busy`=0 after t+9.

## Test plan
- **Reset and init:** release `Reset` with no requests → `LD_REG`=1 with `DR`=0..7 and `Data_In`=0 after edges 1–8; `Init_Busy` falls after edge 9; every register file read returns 0x0000.
- **Single write:** A_Req with A_DR=3, A_Data=0x1234 from edge 10 → `A_Ack`=1, `LD_REG`=1, `DR`=3, `Data_In`=0x1234 for one cycle; R3 reads 0x1234.
- **Contention:** A and B both request continuously after init, with A DR=1/0xAAAA and B DR=2/0x5555, requests re-presented after each Ack → grants go A, B, A, B…; one `LD_REG` per cycle; both Acks are never high in the same cycle.
- **Same-register conflict:** A and B both request DR=5 in the same cycle (A=0x0001, B=0x0002), pointer=A → A is written first, then B; R5 ends as 0x0002.
- **Re-clear with pending request:** `Init_Start` pulse while B_Req is held high → no `B_Ack` during 8 clear writes; `B_Ack` appears on the first sample after `Init_Busy` falls; that register holds B's data and all others read 0.
- **Reset mid-clear:** assert `Reset` after edge 4 → `LD_REG`/`Ack`/`DR` go to 0 immediately; after release, the clear restarts at `DR`=0.

Source files
------------

// File: rtl/regfile_write_arbiter_if.sv
// Write-port bundle between the two requesters, the arbiter and the register file.
// master = requesters/register-file side, slave = arbiter side.
interface regfile_write_arbiter_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
);
  logic              A_Req;
  logic [ADDR_W-1:0] A_DR;
  logic [DATA_W-1:0] A_Data;
  logic              A_Ack;
  logic              B_Req;
  logic [ADDR_W-1:0] B_DR;
  logic [DATA_W-1:0] B_Data;
  logic              B_Ack;
  logic              Init_Start;
  logic              LD_REG;
  logic [ADDR_W-1:0] DR;
  logic [DATA_W-1:0] Data_In;
  logic              Init_Busy;

  modport master (
    output A_Req, A_DR, A_Data, B_Req, B_DR, B_Data, Init_Start,
    input  A_Ack, B_Ack, LD_REG, DR, Data_In, Init_Busy
  );

  modport slave (
    input  A_Req, A_DR, A_Data, B_Req, B_DR, B_Data, Init_Start,
    output A_Ack, B_Ack, LD_REG, DR, Data_In, Init_Busy
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Shares the single register-file write port between the CPU write-back path (A)
// and the debug loader (B). Clears R0..R(NUM_REGS-1) after reset or on Init_Start
// before any request is accepted. All outputs are registered.
module regfile_write_arbiter #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 3,
  parameter int NUM_REGS = 8
) (
  input  logic                    Clk,
  input  logic                    Reset,
  regfile_write_arbiter_if.slave  bus
);

  typedef enum logic {INIT, ARB} state_t;

  // Counter runs one past the last register: that extra cycle is the idle
  // cycle that drops Init_Busy before the first request sample.
  localparam logic [ADDR_W:0] CNT_END = (ADDR_W+1)'(NUM_REGS);

  state_t            state, state_nxt;
  logic [ADDR_W:0]   cnt, cnt_nxt;
  logic              ptr, ptr_nxt;          // 0: A holds priority, 1: B
  logic              ld_q, ld_nxt;
  logic              a_ack_q, a_ack_nxt;
  logic              b_ack_q, b_ack_nxt;
  logic              busy_q, busy_nxt;
  logic [ADDR_W-1:0] dr_q, dr_nxt;
  logic [DATA_W-1:0] data_q, data_nxt;
  logic              a_elig, b_elig, gnt_a, gnt_b;

  // A requester being acked this cycle is not re-sampled at this edge.
  assign a_elig = bus.A_Req & ~a_ack_q;
  assign b_elig = bus.B_Req & ~b_ack_q;
  assign gnt_a  = a_elig & (~b_elig | ~ptr);
  assign gnt_b  = b_elig & (~a_elig |  ptr);

  assign bus.LD_REG    = ld_q;
  assign bus.DR        = dr_q;
  assign bus.Data_In   = data_q;
  assign bus.A_Ack     = a_ack_q;
  assign bus.B_Ack     = b_ack_q;
  assign bus.Init_Busy = busy_q;

  // State and registered outputs.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state   <= INIT;
      cnt     <= '0;
      ptr     <= 1'b0;
      ld_q    <= 1'b0;
      a_ack_q <= 1'b0;
      b_ack_q <= 1'b0;
      busy_q  <= 1'b1;
      dr_q    <= '0;
      data_q  <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      ptr     <= ptr_nxt;
      ld_q    <= ld_nxt;
      a_ack_q <= a_ack_nxt;
      b_ack_q <= b_ack_nxt;
      busy_q  <= busy_nxt;
      dr_q    <= dr_nxt;
      data_q  <= data_nxt;
    end
  end

  // Next state: clear sequence in INIT, round-robin grant in ARB.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ptr_nxt   = ptr;
    ld_nxt    = 1'b0;
    a_ack_nxt = 1'b0;
    b_ack_nxt = 1'b0;
    busy_nxt  = busy_q;
    dr_nxt    = dr_q;
    data_nxt  = data_q;
    case (state)
      INIT: begin
        if (cnt == CNT_END) begin
          state_nxt = ARB;
          busy_nxt  = 1'b0;
          cnt_nxt   = '0;
        end else begin
          ld_nxt   = 1'b1;
          dr_nxt   = cnt[ADDR_W-1:0];
          data_nxt = '0;
          cnt_nxt  = cnt + 1'b1;
        end
      end
      ARB: begin
        if (bus.Init_Start) begin
          // Re-clear wins over requests; pending requesters simply wait.
          state_nxt = INIT;
          cnt_nxt   = '0;
          busy_nxt  = 1'b1;
        end else if (gnt_a) begin
          ld_nxt    = 1'b1;
          a_ack_nxt = 1'b1;
          dr_nxt    = bus.A_DR;
          data_nxt  = bus.A_Data;
          ptr_nxt   = 1'b1;
        end else if (gnt_b) begin
          ld_nxt    = 1'b1;
          b_ack_nxt = 1'b1;
          dr_nxt    = bus.B_DR;
          data_nxt  = bus.B_Data;
          ptr_nxt   = 1'b0;
        end
      end
      default: state_nxt = INIT;
    endcase
  end

endmodule
